// File: rtl/ram_fifo_ctrl.sv
// Deep circular FIFO controller for a single-port synchronous-read RAM, with a 2-entry prefetch buffer.
// Optional level high-water mark tracking is enabled with the RAM_FIFO_HWM_EN macro.
module ram_fifo_ctrl #(
    parameter int unsigned DEPTH_LOG2 = 23,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  mem_we,
    output logic [22:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [23:0]           level,
    output logic [23:0]           hwm
);

    localparam int unsigned ADDR_W = 23;
    localparam int unsigned LVL_W  = 24;
    localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] CAP = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      ram_cnt_q, ram_cnt_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic [1:0]            obuf_cnt_q, obuf_cnt_d;
    logic [DATA_WIDTH-1:0] obuf0_q, obuf0_d;
    logic [DATA_WIDTH-1:0] obuf1_q, obuf1_d;
    logic                  prio_q, prio_d;
    logic [LVL_W-1:0]      level_q, level_d;

    logic       full;
    logic       pop;
    logic       rd_need;
    logic       wr_want;
    logic       do_wr;
    logic       do_rd;
    logic [2:0] occ;
    logic [1:0] cnt_after_pop;

    assign out_valid = (obuf_cnt_q != 2'd0);
    assign out_data  = obuf0_q;
    assign level     = level_q;

    // Port arbitration, RAM drive and next-state for pointers, counts and the output buffer.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        ram_cnt_d     = ram_cnt_q;
        rd_inflight_d = rd_inflight_q;
        obuf_cnt_d    = obuf_cnt_q;
        obuf0_d       = obuf0_q;
        obuf1_d       = obuf1_q;
        prio_d        = prio_q;
        cnt_after_pop = obuf_cnt_q;

        full     = (ram_cnt_q == CAP);
        pop      = out_valid && out_ready;
        occ      = 3'(obuf_cnt_q) + 3'(rd_inflight_q) - 3'(pop);
        rd_need  = (ram_cnt_q != '0) && (occ < 3'd2);
        wr_want  = in_valid && !full && !flush;
        in_ready = reset_n && !full && !flush && !(rd_need && prio_q);
        do_wr    = in_valid && in_ready;
        do_rd    = !do_wr && rd_need && !flush;

        mem_we   = do_wr;
        mem_addr = do_wr ? ADDR_W'(wr_ptr_q) : ADDR_W'(rd_ptr_q);
        mem_din  = do_wr ? in_data : '0;

        if (wr_want && rd_need) begin
            prio_d = !prio_q;
        end

        if (flush) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            ram_cnt_d     = '0;
            rd_inflight_d = 1'b0;
            obuf_cnt_d    = 2'd0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            end
            ram_cnt_d     = ram_cnt_q + CNT_W'(do_wr) - CNT_W'(do_rd);
            rd_inflight_d = do_rd;

            // Pop shifts the buffer first; returning read data lands in the first free slot.
            cnt_after_pop = obuf_cnt_q - 2'(pop);
            if (pop) begin
                obuf0_d = obuf1_q;
            end
            if (rd_inflight_q) begin
                if (cnt_after_pop == 2'd0) begin
                    obuf0_d = mem_dout;
                end else begin
                    obuf1_d = mem_dout;
                end
            end
            obuf_cnt_d = cnt_after_pop + 2'(rd_inflight_q);
        end

        level_d = LVL_W'(ram_cnt_d) + LVL_W'(rd_inflight_d) + LVL_W'(obuf_cnt_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ram_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
            obuf_cnt_q    <= 2'd0;
            obuf0_q       <= '0;
            obuf1_q       <= '0;
            prio_q        <= 1'b0;
            level_q       <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ram_cnt_q     <= ram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            obuf_cnt_q    <= obuf_cnt_d;
            obuf0_q       <= obuf0_d;
            obuf1_q       <= obuf1_d;
            prio_q        <= prio_d;
            level_q       <= level_d;
        end
    end

`ifdef RAM_FIFO_HWM_EN
    logic [LVL_W-1:0] hwm_q;

    // Peak of the registered level, cleared by flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hwm_q <= '0;
        end else if (flush) begin
            hwm_q <= '0;
        end else if (level_q > hwm_q) begin
            hwm_q <= level_q;
        end
    end

    assign hwm = hwm_q;
`else
    assign hwm = '0;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl (DEPTH_LOG2=4) with an attached RAM and a queue-based reference model.
// Define RAM_FIFO_HWM_EN for both bench and RTL to check the high-water mark.
module tb_ram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic [23:0] level;
    logic [23:0] hwm;

    ram_fifo_ctrl #(.DEPTH_LOG2(4), .DATA_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .level(level), .hwm(hwm)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM, only the low address bits are populated
    logic [15:0] ram [0:15];
    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 16'hDEAD;
        mem_dout = 16'h0;
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[3:0]] <= mem_din;
        mem_dout <= ram[mem_addr[3:0]];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words as queues, arbitration from the stated rules
    logic [15:0] m_ram[$];
    logic [15:0] m_ob[$];
    logic [15:0] m_infl_w;
    bit          m_infl;
    bit          m_prio;
    int          m_wcnt, m_rcnt, m_hwm;

    // Last sampled DUT values for pinned checks
    logic        s_we, s_ir, s_ov;
    logic [22:0] s_addr;
    logic [15:0] s_od;
    int          s_lvl;

    // Ordering check for sequential-data phases
    bit          seq_en = 1'b0;
    logic [15:0] exp_out;

    task automatic model_clear(input bit clr_prio);
        m_ram.delete();
        m_ob.delete();
        m_infl = 1'b0;
        m_wcnt = 0;
        m_rcnt = 0;
        m_hwm  = 0;
        if (clr_prio) m_prio = 1'b0;
    endtask

    task automatic cycle(input bit iv, input logic [15:0] id, input bit ordy, input bit fl);
        int          lvl, occ, exp_hwm;
        bit          full, pop, need, ir, wr, rd;
        logic [22:0] ea;
        logic [15:0] tmp;
        @(negedge clk);
        in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
        #1;
        lvl  = m_ram.size() + int'(m_infl) + m_ob.size();
        full = (m_ram.size() == 16);
        pop  = (m_ob.size() != 0) && ordy;
        occ  = m_ob.size() + int'(m_infl) - int'(pop);
        need = (m_ram.size() != 0) && (occ < 2);
        ir   = !full && !fl && !(need && m_prio);
        wr   = iv && ir;
        rd   = !wr && need && !fl;
        ea   = wr ? 23'(m_wcnt % 16) : 23'(m_rcnt % 16);
`ifdef RAM_FIFO_HWM_EN
        exp_hwm = m_hwm;
`else
        exp_hwm = 0;
`endif
        chk("in_ready", 32'(in_ready), 32'(ir));
        chk("mem_we", 32'(mem_we), 32'(wr));
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        chk("mem_din", 32'(mem_din), wr ? 32'(id) : 32'h0);
        chk("out_valid", 32'(out_valid), 32'(m_ob.size() != 0));
        if (m_ob.size() != 0) chk("out_data", 32'(out_data), 32'(m_ob[0]));
        chk("level", 32'(level), 32'(lvl));
        chk("hwm", 32'(hwm), 32'(exp_hwm));
        if (seq_en && out_valid && ordy) begin
            chk("order", 32'(out_data), 32'(exp_out));
            exp_out++;
        end
        s_we = mem_we; s_ir = in_ready; s_ov = out_valid; s_addr = mem_addr;
        s_od = out_data; s_lvl = int'(level);
        if (fl) begin
            model_clear(1'b0);
        end else begin
            if (iv && !full && need) m_prio = !m_prio;
            if (lvl > m_hwm) m_hwm = lvl;
            if (pop) tmp = m_ob.pop_front();
            if (m_infl) m_ob.push_back(m_infl_w);
            if (wr) begin m_ram.push_back(id); m_wcnt++; end
            if (rd) begin m_infl_w = m_ram.pop_front(); m_rcnt++; end
            m_infl = rd;
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        in_valid = 1'b1; in_data = 16'hFFFF; out_ready = 1'b1; flush = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_din", 32'(mem_din), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_hwm", 32'(hwm), 32'h0);
        model_clear(1'b1);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] nxt;
        logic [5:0]  weh;
        logic [15:0] got;
        int          nacc, maxl, wraps;
        logic [22:0] prev_addr;

        // Fill with the read side stalled
        async_reset();
        nxt = 16'h0001; nacc = 0; weh = '0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, nxt, 1'b0, 1'b0);
            if (i < 6) weh[5-i] = s_we;
            if (s_ir) begin nacc++; nxt++; end
        end
        chk("fill_accepted", 32'(nacc), 32'd18);
        chk("fill_in_ready", 32'(s_ir), 32'h0);
        chk("fill_level", 32'(s_lvl), 32'd18);
        chk("fill_head", 32'(s_od), 32'h0001);
        chk("fill_we_pattern", 32'(weh), 32'b110101);
`ifdef RAM_FIFO_HWM_EN
        chk("fill_hwm", 32'(hwm), 32'd18);
`endif

        // Drain with writes still streaming, then drain dry
        seq_en = 1'b1; exp_out = 16'h0001;
        for (int i = 0; i < 60; i++) begin
            cycle(1'b1, nxt, 1'b1, 1'b0);
            if (s_ir) nxt++;
        end
        for (int i = 0; i < 40; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
        seq_en = 1'b0;
        chk("drain_all_out", 32'(exp_out), 32'(nxt));
        chk("drain_empty", 32'(s_ov), 32'h0);

        // Single-word latency into an empty FIFO
        async_reset();
        cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
        chk("lat_we", 32'(s_we), 32'h1);
        chk("lat_waddr", 32'(s_addr), 32'h0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("lat_rd", 32'(s_we), 32'h0);
        chk("lat_raddr", 32'(s_addr), 32'h0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("lat_not_yet", 32'(s_ov), 32'h0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("lat_valid", 32'(s_ov), 32'h1);
        chk("lat_data", 32'(s_od), 32'hBEEF);

        // Flush with a read in flight and data buffered
        async_reset();
        nxt = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, nxt, 1'b0, 1'b0);
            if (s_ir) nxt++;
        end
        cycle(1'b1, 16'h7777, 1'b0, 1'b1);
        chk("flush_pre_level", 32'(s_lvl), 32'd3);
        chk("flush_blocks_wr", 32'(s_ir), 32'h0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        chk("flush_ov", 32'(s_ov), 32'h0);
        chk("flush_level", 32'(s_lvl), 32'h0);
        chk("flush_hwm", 32'(hwm), 32'h0);
        cycle(1'b1, 16'h1234, 1'b1, 1'b0);
        got = 16'h0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
            if (s_ov && got == 16'h0) got = s_od;
        end
        chk("flush_new_data", 32'(got), 32'h1234);

        // Randomized streaming with rare flushes and a mid-stream reset
        async_reset();
        maxl = 0; wraps = 0; prev_addr = '0;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                async_reset();
                cycle(1'b1, 16'h5A5A, 1'b0, 1'b0);
                chk("post_rst_addr", 32'(s_addr), 32'h0);
                chk("post_rst_we", 32'(s_we), 32'h1);
            end
            cycle(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0, ($urandom % 64) == 0);
            if (s_lvl > maxl) maxl = s_lvl;
            if (prev_addr == 23'd15 && s_addr == 23'd0) wraps++;
            prev_addr = s_addr;
        end
        chk("level_max_le_18", 32'(maxl <= 18), 32'h1);
        chk("addr_wrapped", 32'(wraps > 0), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
